register: RTL and testbench

//   Generic parameterised storage register with load enable for the 8-bit CPU datapath.

---
 rtl/register.sv | 35 +++
 tb/tb_register.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/register.sv
// Parameterised storage register with load enable.
// Async active-high reset; output comes straight from the flops.
module register #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next value: load d_in when enabled, otherwise hold.
    // An unknown enable merges both sides instead of silently picking one.
    always_comb begin
        data_d = data_q;
        data_d = enable ? d_in : data_q;
    end

    // Storage flops; reset forces RESET_VALUE without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_out = data_q;

endmodule

// File: tb/tb_register.sv
// Self-checking bench for register: default 8-bit instance and a
// 16-bit instance with a non-zero reset value, scoreboard-driven.
module tb_register;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  d_in;
    logic [7:0]  q_out;

    logic        reset16;
    logic        enable16;
    logic [15:0] d_in16;
    logic [15:0] q_out16;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_checks;
    int n_fails;

    register dut8 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .d_in   (d_in),
        .q_out  (q_out)
    );

    register #(
        .WIDTH       (16),
        .RESET_VALUE (16'hBEEF)
    ) dut16 (
        .clk    (clk),
        .reset  (reset16),
        .enable (enable16),
        .d_in   (d_in16),
        .q_out  (q_out16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input string tag, input logic [15:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic cmp(input logic [15:0] obs);
        sb_entry_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fails++;
            $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_fails++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;

        // t=0: both instances held in reset
        reset    = 1'b1;
        enable   = 1'b0;
        d_in     = 8'h00;
        reset16  = 1'b1;
        enable16 = 1'b0;
        d_in16   = 16'h0000;
        push("rst8_async", 16'h0000);
        push("rst16_value", 16'hBEEF);
        #2;
        cmp({8'h00, q_out});
        cmp(q_out16);

        // t=10: release, load AA at 15
        #8;
        reset  = 1'b0;
        enable = 1'b1;
        d_in   = 8'hAA;
        push("load_aa", 16'h00AA);
        #6;
        cmp({8'h00, q_out});

        // t=20: hold with FF on d_in
        #4;
        enable = 1'b0;
        d_in   = 8'hFF;
        push("hold_aa", 16'h00AA);
        #6;
        cmp({8'h00, q_out});

        // t=30: reload CC at 35
        #4;
        enable = 1'b1;
        d_in   = 8'hCC;
        push("load_cc", 16'h00CC);
        #6;
        cmp({8'h00, q_out});
        push("cc_steady", 16'h00CC);
        #5;
        cmp({8'h00, q_out});

        // t=42: async reset between edges
        #1;
        reset = 1'b1;
        push("async_clear", 16'h0000);
        #1;
        cmp({8'h00, q_out});
        enable = 1'b1;
        d_in   = 8'h5A;
        push("reset_dominates", 16'h0000);
        #13;
        cmp({8'h00, q_out});

        // t=58: release has no side effect
        #2;
        reset = 1'b0;
        push("release_quiet", 16'h0000);
        #1;
        cmp({8'h00, q_out});

        // first edge after release (65) loads 5A
        push("post_release_load", 16'h005A);
        #7;
        cmp({8'h00, q_out});

        // t=68: d_in/enable change between edges, then hold edge
        #2;
        enable = 1'b0;
        d_in   = 8'h33;
        push("no_follow", 16'h005A);
        #1;
        cmp({8'h00, q_out});
        push("hold_edge", 16'h005A);
        #7;
        cmp({8'h00, q_out});

        // t=76: all-ones then all-zeros loads
        enable = 1'b1;
        d_in   = 8'hFF;
        push("load_ones", 16'h00FF);
        #10;
        cmp({8'h00, q_out});
        d_in = 8'h00;
        push("load_zeros", 16'h0000);
        #10;
        cmp({8'h00, q_out});

        // t=96: 16-bit instance load and hold
        reset16  = 1'b0;
        enable16 = 1'b1;
        d_in16   = 16'h1234;
        push("load16", 16'h1234);
        #10;
        cmp(q_out16);
        enable16 = 1'b0;
        d_in16   = 16'hFFFF;
        push("hold16", 16'h1234);
        #10;
        cmp(q_out16);

        // t=117: async reset on 16-bit instance
        #1;
        reset16 = 1'b1;
        push("async16", 16'hBEEF);
        #1;
        cmp(q_out16);

        n_checks++;
        assert (sb_q.size() == 0) else begin
            n_fails++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
